// File: rtl/exp4_condicionador_entradas.sv
// -----------------------------------------------------------------------------
// exp4_condicionador_entradas
//
// Input-conditioning stage that sits in front of the circuit top level.
// It takes the raw start button and the four key switches and does three things:
// it brings them into the clock domain, filters out switch bounce, and turns
// committed rising transitions into single-cycle event pulses for the control
// unit and datapath.
//
// All five inputs are filtered together as one vector. A change on any bit
// restarts the filter for the whole vector, so iniciar and chaves always
// commit together and stay consistent with each other.
//
// Parameters
//   DEBOUNCE_CICLOS  clock edges a synchronised value must stay constant before
//                    it is committed (minimum 2; board builds override it).
//   CW               debounce counter width; 2**CW must exceed DEBOUNCE_CICLOS.
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-high
//   iniciar_raw      in   raw start button (asynchronous to clock)
//   chaves_raw[3:0]  in   raw key switches (asynchronous to clock)
//   iniciar_pulso    out  one-cycle pulse on a committed 0->1 of iniciar
//   jogada_pulso     out  one-cycle pulse on a committed chaves 0000 -> nonzero
//   chaves_estaveis  out  committed, debounced key value
//   iniciar_estavel  out  committed, debounced iniciar level
//   chave_valida     out  chaves_estaveis has exactly one bit set
//   db_estado[3:0]   out  filter state for the hex debug display
//                         (4'h0 = ESTAVEL, 4'h1 = FILTRANDO)
// -----------------------------------------------------------------------------
module exp4_condicionador_entradas #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int CW              = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar_raw,
  input  logic [3:0] chaves_raw,
  output logic       iniciar_pulso,
  output logic       jogada_pulso,
  output logic [3:0] chaves_estaveis,
  output logic       iniciar_estavel,
  output logic       chave_valida,
  output logic [3:0] db_estado
);

  typedef enum logic {
    ESTAVEL   = 1'b0,
    FILTRANDO = 1'b1
  } estado_t;

  // Counter value at which the candidate has been seen on DEBOUNCE_CICLOS
  // consecutive edges (the edge that started filtering counts as 1).
  localparam logic [CW-1:0] CNT_FINAL = CW'(DEBOUNCE_CICLOS - 1);

  // Two-flop synchroniser on the whole raw vector {iniciar, chaves}.
  logic [4:0] sync1_reg;
  logic [4:0] sync2_reg;
  logic [4:0] s;

  // Filter state.
  estado_t    state_reg, state_next;
  logic [4:0] est_reg,   est_next;
  logic [4:0] cand_reg,  cand_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic       iniciar_pulso_reg, iniciar_pulso_next;
  logic       jogada_pulso_reg,  jogada_pulso_next;
  logic       commit;

  assign s = sync2_reg;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_reg <= 5'b0;
      sync2_reg <= 5'b0;
    end else begin
      sync1_reg <= {iniciar_raw, chaves_raw};
      sync2_reg <= sync1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Filter FSM: state and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= ESTAVEL;
      est_reg           <= 5'b0;
      cand_reg          <= 5'b0;
      cnt_reg           <= '0;
      iniciar_pulso_reg <= 1'b0;
      jogada_pulso_reg  <= 1'b0;
    end else begin
      state_reg         <= state_next;
      est_reg           <= est_next;
      cand_reg          <= cand_next;
      cnt_reg           <= cnt_next;
      iniciar_pulso_reg <= iniciar_pulso_next;
      jogada_pulso_reg  <= jogada_pulso_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Filter FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    est_next   = est_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;

    case (state_reg)
      ESTAVEL: begin
        if (s != est_reg) begin
          cand_next  = s;
          cnt_next   = CW'(1);
          state_next = FILTRANDO;
        end
      end

      FILTRANDO: begin
        if (s == est_reg) begin
          // Input bounced back to the committed value: drop the candidate.
          state_next = ESTAVEL;
        end else if (s != cand_reg) begin
          // Input moved again: restart filtering on the new value.
          cand_next = s;
          cnt_next  = CW'(1);
        end else if (cnt_reg == CNT_FINAL) begin
          commit     = 1'b1;
          est_next   = cand_reg;
          state_next = ESTAVEL;
        end else begin
          // Bounded by CNT_FINAL above, so the counter never wraps.
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next = ESTAVEL;
      end
    endcase

    // Pulses only on commits that are rising in the sense the control unit
    // cares about; falling edges and nonzero->nonzero key changes are silent.
    iniciar_pulso_next = commit & cand_reg[4] & ~est_reg[4];
    jogada_pulso_next  = commit & (cand_reg[3:0] != 4'b0) & (est_reg[3:0] == 4'b0);
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign iniciar_pulso   = iniciar_pulso_reg;
  assign jogada_pulso    = jogada_pulso_reg;
  assign iniciar_estavel = est_reg[4];
  assign chaves_estaveis = est_reg[3:0];
  assign chave_valida    = $onehot(est_reg[3:0]);
  assign db_estado       = {3'b000, (state_reg == FILTRANDO)};

endmodule

// File: tb/tb_exp4_condicionador_entradas.sv
// -----------------------------------------------------------------------------
// Testbench for exp4_condicionador_entradas (DEBOUNCE_CICLOS = 4).
//
// A reference model runs on every rising edge and pushes the expected outputs
// for that edge into a scoreboard queue; a monitor pops them 1 time unit after
// the same edge and compares against the DUT. The model describes the filter
// as "commit when the synchronised value has been seen on exactly D
// consecutive edges and differs from the committed value", and the FSM state
// as "filtering whenever the synchronised value differs from the committed
// one". Directed scenarios add latency and pulse-count checks on top.
// -----------------------------------------------------------------------------
module tb_exp4_condicionador_entradas;

  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar_raw = 1'b0;
  logic [3:0] chaves_raw = 4'b0;
  logic       iniciar_pulso;
  logic       jogada_pulso;
  logic [3:0] chaves_estaveis;
  logic       iniciar_estavel;
  logic       chave_valida;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_errors = 0;

  exp4_condicionador_entradas #(
    .DEBOUNCE_CICLOS(D),
    .CW(16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .iniciar_raw     (iniciar_raw),
    .chaves_raw      (chaves_raw),
    .iniciar_pulso   (iniciar_pulso),
    .jogada_pulso    (jogada_pulso),
    .chaves_estaveis (chaves_estaveis),
    .iniciar_estavel (iniciar_estavel),
    .chave_valida    (chave_valida),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0] est;
    logic       pi;
    logic       pj;
    logic       filt;
  } exp_t;

  exp_t sb_q[$];

  logic [4:0] m_sync1 = 5'b0;
  logic [4:0] m_sync2 = 5'b0;
  logic [4:0] m_est   = 5'b0;
  logic [4:0] m_run_val = 5'b0;
  int         m_run_len = D + 1;

  always @(posedge clock) begin
    exp_t e;
    logic [4:0] s_now;
    e.pi = 1'b0;
    e.pj = 1'b0;
    e.filt = 1'b0;
    if (reset) begin
      m_sync1   = 5'b0;
      m_sync2   = 5'b0;
      m_est     = 5'b0;
      m_run_val = 5'b0;
      m_run_len = D + 1;
    end else begin
      s_now   = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = {iniciar_raw, chaves_raw};
      if (s_now == m_run_val) begin
        if (m_run_len <= D) m_run_len++;
      end else begin
        m_run_val = s_now;
        m_run_len = 1;
      end
      if (m_run_len == D && m_run_val != m_est) begin
        e.pi  = m_run_val[4] & ~m_est[4];
        e.pj  = (m_run_val[3:0] != 4'b0) && (m_est[3:0] == 4'b0);
        m_est = m_run_val;
      end
      e.filt = (s_now != m_est);
    end
    e.est = m_est;
    sb_q.push_back(e);
  end

  int ini_pulses = 0;
  int jog_pulses = 0;

  always @(posedge clock) begin
    exp_t e;
    #1;
    ini_pulses += int'(iniciar_pulso);
    jog_pulses += int'(jogada_pulso);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_chaves",    {4'b0, chaves_estaveis}, {4'b0, e.est[3:0]});
      check("sb_iniciar",   {7'b0, iniciar_estavel}, {7'b0, e.est[4]});
      check("sb_ini_pulso", {7'b0, iniciar_pulso},   {7'b0, e.pi});
      check("sb_jog_pulso", {7'b0, jogada_pulso},    {7'b0, e.pj});
      check("sb_valida",    {7'b0, chave_valida},    {7'b0, $countones(e.est[3:0]) == 1});
      check("sb_db_estado", {4'b0, db_estado},       {7'b0, e.filt});
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Counts rising edges after the current drive point until either pulse is
  // seen; -1 if none appears within the bound.
  task automatic measure(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (iniciar_pulso || jogada_pulso) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {iniciar_pulso, jogada_pulso, iniciar_estavel, chave_valida, chaves_estaveis}, 8'h00);
    check({tag, "_db"}, {4'b0, db_estado}, 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    int base_i;
    int base_j;

    // 1. Reset with raw inputs held high.
    iniciar_raw = 1'b1;
    chaves_raw  = 4'b1111;
    idle(3);
    #1;
    check_all_zero("t1_reset");
    $display("txn t1: reset with raw=1, outputs all zero");
    @(negedge clock);
    reset = 1'b0;
    measure(lat);
    check("t1_release_lat", 8'(lat), 8'd6);
    check("t1_release_ini", {7'b0, iniciar_estavel}, 8'd1);
    idle(2);
    iniciar_raw = 1'b0;
    chaves_raw  = 4'b0000;
    idle(10);
    check("t1_back_zero", {3'b0, iniciar_estavel, chaves_estaveis}, 8'h00);

    // 2. Single key press.
    chaves_raw = 4'b0100;
    measure(lat);
    $display("txn t2: chaves 0000->0100, pulse at edge %0d", lat);
    check("t2_lat",    8'(lat), 8'd6);
    check("t2_chaves", {4'b0, chaves_estaveis}, 8'h04);
    check("t2_pulse",  {7'b0, jogada_pulso}, 8'd1);
    check("t2_valida", {7'b0, chave_valida}, 8'd1);
    @(posedge clock);
    #1;
    check("t2_pulse_width", {7'b0, jogada_pulso}, 8'd0);
    @(negedge clock);
    chaves_raw = 4'b0000;
    idle(10);

    // 3. Bouncing key, then a clean hold.
    base_j = jog_pulses;
    for (int i = 0; i < 6; i++) begin
      chaves_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      idle(2);
    end
    check("t3_no_bounce_pulse", 8'(jog_pulses - base_j), 8'd0);
    check("t3_est_during", {4'b0, chaves_estaveis}, 8'h00);
    chaves_raw = 4'b0100;
    measure(lat);
    $display("txn t3: bounce then hold 0100, pulse at edge %0d", lat);
    check("t3_lat", 8'(lat), 8'd6);
    idle(8);
    check("t3_one_pulse", 8'(jog_pulses - base_j), 8'd1);
    chaves_raw = 4'b0000;
    idle(10);

    // 4. Short iniciar glitch.
    base_i = ini_pulses;
    iniciar_raw = 1'b1;
    idle(3);
    iniciar_raw = 1'b0;
    idle(10);
    $display("txn t4: iniciar high 3 cycles, rejected");
    check("t4_ini_est",   {7'b0, iniciar_estavel}, 8'd0);
    check("t4_no_pulse",  8'(ini_pulses - base_i), 8'd0);
    check("t4_db_estado", {4'b0, db_estado}, 8'h00);

    // 5. iniciar and chaves together.
    iniciar_raw = 1'b1;
    chaves_raw  = 4'b0011;
    measure(lat);
    $display("txn t5: iniciar+chaves 0011, pulse at edge %0d", lat);
    check("t5_lat",     8'(lat), 8'd6);
    check("t5_pulses",  {6'b0, iniciar_pulso, jogada_pulso}, 8'b11);
    check("t5_chaves",  {4'b0, chaves_estaveis}, 8'h03);
    check("t5_valida",  {7'b0, chave_valida}, 8'd0);
    @(negedge clock);
    iniciar_raw = 1'b0;
    chaves_raw  = 4'b0000;
    idle(10);

    // 6. Reset in the middle of filtering, then nonzero->nonzero change.
    chaves_raw = 4'b1000;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_all_zero("t6_reset");
    @(negedge clock);
    reset = 1'b0;
    measure(lat);
    $display("txn t6: reset mid-filter, chaves 1000 pulse at edge %0d after release", lat);
    check("t6_lat",    8'(lat), 8'd6);
    check("t6_chaves", {4'b0, chaves_estaveis}, 8'h08);
    check("t6_pulse",  {7'b0, jogada_pulso}, 8'd1);
    @(negedge clock);
    base_j = jog_pulses;
    chaves_raw = 4'b0001;
    idle(10);
    $display("txn t6: chaves 1000->0001, no pulse expected");
    check("t6_est_0001",   {4'b0, chaves_estaveis}, 8'h01);
    check("t6_nz_no_pulse", 8'(jog_pulses - base_j), 8'd0);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
